// File: rtl/neuromorphic_x1_pkg.sv
// Shared types and constants for the Neuromorphic X1 Wishbone sequencer.
package neuromorphic_x1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  localparam logic [3:0]  X1_SEL_FULL               = 4'hF;
  localparam logic [31:0] X1_DEFAULT_BASE_ADDR      = 32'h3000_0000;
  localparam int          X1_DEFAULT_TIMEOUT_CYCLES = 255;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] dat;
  } x1_rsp_t;

  // Word offset to byte address; wraps modulo 2^32.
  function automatic logic [31:0] x1_byte_addr(input logic [31:0] base,
                                               input logic [15:0] word_adr);
    return base + {14'd0, word_adr, 2'b00};
  endfunction

endpackage

// File: rtl/nx1_timeout_ctr.sv
// Clear/enable cycle counter; expire pulses during the LIMIT-th enabled cycle.
module nx1_timeout_ctr #(
  parameter int LIMIT = 255,
  localparam int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      count_reg <= '0;
    end else if (en && !expire) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expire = en && (count_reg == LAST);

endmodule

// File: rtl/neuromorphic_x1_wb_sequencer.sv
// Command/response stream to classic Wishbone master bridge for the X1 slave,
// one bus cycle per command with a bounded wait for ack.
module neuromorphic_x1_wb_sequencer
  import neuromorphic_x1_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = X1_DEFAULT_BASE_ADDR,
  parameter int          TIMEOUT_CYCLES = X1_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [15:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic        rsp_we_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o,
  output logic [7:0]  timeout_cnt_o
);

  seq_state_e  state_reg, state_next;
  logic        accept;
  logic        tmo_expire;
  logic        we_reg;
  logic [31:0] adr_reg;
  logic [31:0] dat_reg;
  x1_rsp_t     rsp_reg;
  logic [7:0]  timeout_cnt_reg;

  nx1_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (wb_clk_i),
    .srst   (wb_rst_i),
    .clr    (accept),
    .en     (state_reg == BUS),
    .expire (tmo_expire)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    wbm_cyc_o   = 1'b0;
    busy_o      = 1'b1;
    case (state_reg)
      IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_valid_i) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        wbm_cyc_o = 1'b1;
        // An ack arriving in the expiry cycle still completes normally.
        if (wbm_ack_i || tmo_expire) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      we_reg          <= 1'b0;
      adr_reg         <= '0;
      dat_reg         <= '0;
      rsp_reg         <= '0;
      timeout_cnt_reg <= '0;
    end else begin
      if (accept) begin
        we_reg  <= cmd_we_i;
        adr_reg <= x1_byte_addr(BASE_ADDR, cmd_adr_i);
        dat_reg <= cmd_dat_i;
      end
      if (state_reg == BUS) begin
        if (wbm_ack_i) begin
          rsp_reg <= '{we: we_reg, err: 1'b0, dat: (we_reg ? 32'd0 : wbm_dat_i)};
        end else if (tmo_expire) begin
          rsp_reg <= '{we: we_reg, err: 1'b1, dat: 32'd0};
          if (timeout_cnt_reg != 8'hFF) begin
            timeout_cnt_reg <= timeout_cnt_reg + 8'd1;
          end
        end
      end
    end
  end

  assign wbm_stb_o     = wbm_cyc_o;
  assign wbm_we_o      = wbm_cyc_o & we_reg;
  assign wbm_sel_o     = X1_SEL_FULL;
  assign wbm_adr_o     = adr_reg;
  assign wbm_dat_o     = dat_reg;
  assign rsp_we_o      = rsp_reg.we;
  assign rsp_err_o     = rsp_reg.err;
  assign rsp_dat_o     = rsp_reg.dat;
  assign timeout_cnt_o = timeout_cnt_reg;

endmodule

// File: tb/tb_neuromorphic_x1_wb_sequencer.sv
// Self-checking bench: emulated X1 slave with programmable ack delay and a
// transaction-level reference model of responses and timeout counting.
`timescale 1ns/1ps
module tb_neuromorphic_x1_wb_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TO   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [15:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_we_o, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        busy_o;
  logic [7:0]  timeout_cnt_o;

  int checks = 0;
  int errors = 0;
  int model_tcnt = 0;

  always #5 clk = ~clk;

  neuromorphic_x1_wb_sequencer #(
    .BASE_ADDR      (BASE),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_we_i      (cmd_we_i),
    .cmd_adr_i     (cmd_adr_i),
    .cmd_dat_i     (cmd_dat_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_we_o      (rsp_we_o),
    .rsp_dat_o     (rsp_dat_o),
    .rsp_err_o     (rsp_err_o),
    .wbm_cyc_o     (wbm_cyc_o),
    .wbm_stb_o     (wbm_stb_o),
    .wbm_we_o      (wbm_we_o),
    .wbm_sel_o     (wbm_sel_o),
    .wbm_adr_o     (wbm_adr_o),
    .wbm_dat_o     (wbm_dat_o),
    .wbm_dat_i     (wbm_dat_i),
    .wbm_ack_i     (wbm_ack_i),
    .busy_o        (busy_o),
    .timeout_cnt_o (timeout_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One command end to end. ack_at = strobe cycle in which the slave acks
  // (0 = never); hold = cycles of response backpressure.
  task automatic do_txn(input bit we, input logic [15:0] adr, input logic [31:0] dat,
                        input int ack_at, input logic [31:0] rdata, input int hold,
                        input bit late_ack, input bit pend);
    logic [31:0] exp_adr, exp_dat;
    bit          exp_err;
    int          exp_stb, stb_n, edges;
    exp_adr = BASE + 32'(adr) * 32'd4;
    exp_err = (ack_at < 1) || (ack_at > TO);
    exp_stb = exp_err ? TO : ack_at;
    exp_dat = (exp_err || we) ? 32'd0 : rdata;
    if (exp_err && model_tcnt < 255) model_tcnt++;

    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle got=%b exp=1", cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    tick();
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'($urandom);
    cmd_adr_i   = 16'($urandom);
    cmd_dat_i   = $urandom;

    stb_n = 0;
    edges = 0;
    while (rsp_valid_o !== 1'b1 && edges < 100) begin
      if (wbm_stb_o === 1'b1) begin
        stb_n++;
        checks++;
        if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== exp_adr || wbm_we_o !== we ||
            wbm_dat_o !== dat || wbm_sel_o !== 4'hF || cmd_ready_o !== 1'b0) begin
          errors++;
          $display("FAIL bus adr got=%h exp=%h we got=%b exp=%b dat got=%h exp=%h sel=%h",
                   wbm_adr_o, exp_adr, wbm_we_o, we, wbm_dat_o, dat, wbm_sel_o);
        end
        wbm_ack_i = (stb_n == ack_at);
        wbm_dat_i = wbm_ack_i ? rdata : $urandom;
      end
      tick();
      edges++;
      wbm_ack_i = 1'b0;
    end

    checks++;
    if (stb_n != exp_stb || edges != exp_stb) begin
      errors++;
      $display("FAIL stb_len stb got=%0d exp=%0d rsp_edges got=%0d exp=%0d",
               stb_n, exp_stb, edges, exp_stb);
    end
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_we_o !== we || rsp_err_o !== exp_err ||
        rsp_dat_o !== exp_dat || wbm_stb_o !== 1'b0 || busy_o !== 1'b1 || cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rsp valid=%b we got=%b exp=%b err got=%b exp=%b dat got=%h exp=%h stb=%b",
               rsp_valid_o, rsp_we_o, we, rsp_err_o, exp_err, rsp_dat_o, exp_dat, wbm_stb_o);
    end
    checks++;
    if (timeout_cnt_o !== 8'(model_tcnt)) begin
      errors++;
      $display("FAIL timeout_cnt got=%0d exp=%0d", timeout_cnt_o, model_tcnt);
    end

    for (int i = 0; i < hold; i++) begin
      if (pend) cmd_valid_i = 1'b1;
      if (late_ack && i == 1) begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = $urandom;
      end else begin
        wbm_ack_i = 1'b0;
      end
      tick();
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_we_o !== we || rsp_err_o !== exp_err ||
          rsp_dat_o !== exp_dat || timeout_cnt_o !== 8'(model_tcnt) ||
          wbm_stb_o !== 1'b0 || cmd_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL hold cyc=%0d valid=%b err got=%b exp=%b dat got=%h exp=%h tcnt got=%0d exp=%0d stb=%b rdy=%b",
                 i, rsp_valid_o, rsp_err_o, exp_err, rsp_dat_o, exp_dat,
                 timeout_cnt_o, model_tcnt, wbm_stb_o, cmd_ready_o);
      end
    end
    wbm_ack_i   = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      errors++;
      $display("FAIL handshake valid got=%b exp=0 ready got=%b exp=1 busy got=%b exp=0 stb=%b",
               rsp_valid_o, cmd_ready_o, busy_o, wbm_stb_o);
    end
    $display("txn we=%0d adr=%h ack_at=%0d stb=%0d err=%0d dat=%h tcnt=%0d",
             we, adr, ack_at, stb_n, rsp_err_o, rsp_dat_o, timeout_cnt_o);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (cmd_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_we_o !== 1'b0 ||
        rsp_dat_o !== 32'd0 || rsp_err_o !== 1'b0 || wbm_cyc_o !== 1'b0 ||
        wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0 || wbm_adr_o !== 32'd0 ||
        wbm_dat_o !== 32'd0 || busy_o !== 1'b0 || timeout_cnt_o !== 8'd0 ||
        wbm_sel_o !== 4'hF) begin
      errors++;
      $display("FAIL %s got rdy=%b vld=%b we=%b dat=%h err=%b cyc=%b stb=%b wwe=%b adr=%h wdat=%h busy=%b tcnt=%0d sel=%h (exp reset values)",
               tag, cmd_ready_o, rsp_valid_o, rsp_we_o, rsp_dat_o, rsp_err_o, wbm_cyc_o,
               wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, busy_o, timeout_cnt_o, wbm_sel_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    check_reset_values("reset_state");
    rst = 1'b0;
    tick();
    check_reset_values("post_reset_idle");
    model_tcnt = 0;
  endtask

  task automatic test_write_basic();
    do_txn(1'b1, 16'h0004, 32'hA5A5_0001, 1, 32'h1234_5678, 0, 1'b0, 1'b0);
  endtask

  task automatic test_read_wait();
    do_txn(1'b0, 16'h0000, 32'h0, 4, 32'hDEAD_BEEF, 1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout_late_ack();
    do_txn(1'b0, 16'h0123, 32'h0, 0, 32'h0, 4, 1'b1, 1'b0);
  endtask

  task automatic test_ack_on_expiry();
    do_txn(1'b1, 16'hFFFF, 32'hCAFE_0004, TO, 32'h5555_AAAA, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_txn(1'b0, 16'h0010, 32'h0, 2, 32'h0BAD_F00D, 10, 1'b0, 1'b1);
    do_txn(1'b1, 16'h0011, 32'h7777_0011, 1, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_spurious_ack();
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hFFFF_FFFF;
    repeat (2) begin
      tick();
      checks++;
      if (wbm_stb_o !== 1'b0 || rsp_valid_o !== 1'b0 || busy_o !== 1'b0 ||
          timeout_cnt_o !== 8'(model_tcnt)) begin
        errors++;
        $display("FAIL spurious_ack stb=%b vld=%b busy=%b tcnt got=%0d exp=%0d",
                 wbm_stb_o, rsp_valid_o, busy_o, timeout_cnt_o, model_tcnt);
      end
    end
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), 16'($urandom), $urandom, int'($urandom_range(0, TO + 1)),
             $urandom, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid_i = 1'b1;
    cmd_we_i    = 1'b1;
    cmd_adr_i   = 16'h0042;
    cmd_dat_i   = 32'h1357_9BDF;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    checks++;
    if (wbm_stb_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_bus stb got=%b exp=1", wbm_stb_o);
    end
    rst = 1'b1;
    tick();
    check_reset_values("reset_mid_bus");
    rst = 1'b0;
    model_tcnt = 0;
    repeat (6) begin
      tick();
      checks++;
      if (rsp_valid_o !== 1'b0 || wbm_stb_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
        errors++;
        $display("FAIL after_reset vld got=%b exp=0 stb got=%b exp=0 rdy got=%b exp=1",
                 rsp_valid_o, wbm_stb_o, cmd_ready_o);
      end
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      do_txn(1'($urandom), 16'($urandom), $urandom, 0, 32'h0, 0, 1'b0, 1'b0);
    end
    checks++;
    if (timeout_cnt_o !== 8'd255) begin
      errors++;
      $display("FAIL saturation got=%0d exp=255", timeout_cnt_o);
    end
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'b0;
    cmd_adr_i   = '0;
    cmd_dat_i   = '0;
    rsp_ready_i = 1'b0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_timeout_late_ack();
    test_ack_on_expiry();
    test_back_to_back();
    test_spurious_ack();
    test_random();
    test_reset_mid();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
